// File: rtl/sdram_scheduler.sv
// sdram_scheduler: shares the SDRAM command bus between the read and write engines
// with round-robin grants, and owns periodic PRECHARGE-ALL + AUTO REFRESH.
// Define SDRAM_SCHED_STATS_EN to enable the refresh/grant statistics counters.
module sdram_scheduler #(
   parameter int REFRESH_INTERVAL = 780,
   parameter int T_RP             = 2,
   parameter int T_RFC            = 7,
   parameter int MAX_HOLD         = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_done_i,
   input  logic        rd_request_i,
   input  logic        wr_request_i,
   output logic        rd_enable_o,
   output logic        wr_enable_o,
   input  logic        rd_idle_i,
   input  logic        wr_idle_i,
   output logic        auto_refresh_o,
   input  logic [2:0]  rd_command_i,
   input  logic [11:0] rd_address_i,
   input  logic [1:0]  rd_bank_i,
   input  logic [2:0]  wr_command_i,
   input  logic [11:0] wr_address_i,
   input  logic [1:0]  wr_bank_i,
   output logic [2:0]  sd_command_o,
   output logic [11:0] sd_address_o,
   output logic [1:0]  sd_bank_o,
   output logic        refresh_late_o,
   output logic [15:0] refresh_count_o,
   output logic [15:0] rd_grant_count_o,
   output logic [15:0] wr_grant_count_o
);
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_AR  = 3'b001;
   localparam int TW = $clog2(REFRESH_INTERVAL + 1);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int DW = $clog2((T_RP > T_RFC ? T_RP : T_RFC) + 1);

   typedef enum logic [2:0] {IDLE, GRANT_RD, GRANT_WR, DRAIN, REF_PRE, REF_AR, REF_WAIT} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_RD, SEL_WR} sel_t;

   state_t        state_q, state_d;
   sel_t          sel_q, sel_d;
   logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic          ar_q, ar_d, pend_q, pend_d, late_q, late_d, last_wr_q, last_wr_d;
   logic [2:0]    cmd_q, cmd_d;
   logic [11:0]   addr_q, addr_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [DW-1:0] dly_q, dly_d;
   logic          expire, pend, grant_rd, grant_wr, start_ref, own_req, oth_req;

   // refresh timer: frozen until init completes, a second expiry while still pending is late
   assign expire = init_done_i && tmr_q == '0;
   assign pend   = pend_q | expire;
   assign tmr_d  = !init_done_i ? tmr_q : expire ? TW'(REFRESH_INTERVAL) : tmr_q - 1'b1;
   assign late_d = late_q | (expire & pend_q);

   // pins follow the registered grant with no extra latency
   assign sd_command_o   = sel_q == SEL_RD ? rd_command_i : sel_q == SEL_WR ? wr_command_i : cmd_q;
   assign sd_address_o   = sel_q == SEL_RD ? rd_address_i : sel_q == SEL_WR ? wr_address_i : addr_q;
   assign sd_bank_o      = sel_q == SEL_RD ? rd_bank_i : sel_q == SEL_WR ? wr_bank_i : 2'd0;
   assign rd_enable_o    = rd_en_q;
   assign wr_enable_o    = wr_en_q;
   assign auto_refresh_o = ar_q;
   assign refresh_late_o = late_q;

   // arbitration, drain and refresh sequencing
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rd_en_d   = rd_en_q;
      wr_en_d   = wr_en_q;
      ar_d      = ar_q;
      pend_d    = pend;
      last_wr_d = last_wr_q;
      cmd_d     = CMD_NOP;
      addr_d    = '0;
      hold_d    = hold_q == HW'(MAX_HOLD - 1) ? hold_q : hold_q + 1'b1;
      dly_d     = dly_q + 1'b1;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      start_ref = 1'b0;
      own_req   = state_q == GRANT_RD ? rd_request_i : wr_request_i;
      oth_req   = state_q == GRANT_RD ? wr_request_i : rd_request_i;
      case (state_q)
         IDLE: if (init_done_i) begin
            start_ref = pend;
            grant_rd  = !pend && rd_request_i && (!wr_request_i || last_wr_q);
            grant_wr  = !pend && wr_request_i && !grant_rd;
         end
         GRANT_RD, GRANT_WR:
            if (pend || !own_req || (hold_q == HW'(MAX_HOLD - 1) && oth_req)) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
               wr_en_d = 1'b0;
               ar_d    = pend;
            end
         DRAIN: begin
            ar_d = ar_q | pend;
            if (sel_q == SEL_RD ? rd_idle_i : wr_idle_i) begin
               sel_d     = SEL_NONE;
               state_d   = IDLE;
               start_ref = pend;
            end
         end
         REF_PRE: if (dly_q == DW'(T_RP)) begin
            state_d = REF_AR;
            cmd_d   = CMD_AR;
            dly_d   = '0;
         end
         REF_AR: if (dly_q == DW'(T_RFC)) state_d = REF_WAIT;
         REF_WAIT: begin
            state_d = IDLE;
            ar_d    = 1'b0;
            pend_d  = expire;
         end
         default: state_d = IDLE;
      endcase
      if (start_ref) begin
         state_d = REF_PRE;
         ar_d    = 1'b1;
         cmd_d   = CMD_PRE;
         addr_d  = 12'h400;
         dly_d   = '0;
      end
      if (grant_rd || grant_wr) begin
         state_d   = grant_rd ? GRANT_RD : GRANT_WR;
         sel_d     = grant_rd ? SEL_RD : SEL_WR;
         rd_en_d   = grant_rd;
         wr_en_d   = grant_wr;
         last_wr_d = grant_wr;
         hold_d    = '0;
      end
   end

   // state and registered outputs, all cleared at once by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= SEL_NONE;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         ar_q      <= 1'b0;
         pend_q    <= 1'b0;
         late_q    <= 1'b0;
         last_wr_q <= 1'b1;
         cmd_q     <= CMD_NOP;
         addr_q    <= '0;
         tmr_q     <= TW'(REFRESH_INTERVAL);
         hold_q    <= '0;
         dly_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         ar_q      <= ar_d;
         pend_q    <= pend_d;
         late_q    <= late_d;
         last_wr_q <= last_wr_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         tmr_q     <= tmr_d;
         hold_q    <= hold_d;
         dly_q     <= dly_d;
      end
   end

`ifdef SDRAM_SCHED_STATS_EN
   logic [15:0] ref_cnt_q, rd_cnt_q, wr_cnt_q;

   // wrapping statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_q <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         ref_cnt_q <= ref_cnt_q + 16'(state_q == REF_WAIT);
         rd_cnt_q  <= rd_cnt_q + 16'(grant_rd);
         wr_cnt_q  <= wr_cnt_q + 16'(grant_wr);
      end
   end

   assign refresh_count_o  = ref_cnt_q;
   assign rd_grant_count_o = rd_cnt_q;
   assign wr_grant_count_o = wr_cnt_q;
`else
   assign refresh_count_o  = '0;
   assign rd_grant_count_o = '0;
   assign wr_grant_count_o = '0;
`endif
endmodule

// File: tb/tb_sdram_scheduler.sv
// tb_sdram_scheduler: directed stimulus with a procedural reference model of the scheduler.
module tb_sdram_scheduler;
   localparam int RI = 780, T_RP = 2, T_RFC = 7, MH = 16;
   localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, AR = 3'b001, RDC = 3'b101, WRC = 3'b100;
`ifdef SDRAM_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, init_done = 1'b0;
   logic rd_request = 1'b0, wr_request = 1'b0, rd_idle = 1'b1, wr_idle = 1'b1;
   logic [2:0]  rd_command = RDC, wr_command = WRC;
   logic [11:0] rd_address = 12'h123, wr_address = 12'hABC;
   logic [1:0]  rd_bank = 2'd1, wr_bank = 2'd2;
   logic rd_enable, wr_enable, auto_refresh, refresh_late;
   logic [2:0]  sd_command;
   logic [11:0] sd_address;
   logic [1:0]  sd_bank;
   logic [15:0] refresh_count, rd_grant_count, wr_grant_count;

   sdram_scheduler #(.REFRESH_INTERVAL(RI), .T_RP(T_RP), .T_RFC(T_RFC), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .init_done_i(init_done),
      .rd_request_i(rd_request), .wr_request_i(wr_request),
      .rd_enable_o(rd_enable), .wr_enable_o(wr_enable),
      .rd_idle_i(rd_idle), .wr_idle_i(wr_idle), .auto_refresh_o(auto_refresh),
      .rd_command_i(rd_command), .rd_address_i(rd_address), .rd_bank_i(rd_bank),
      .wr_command_i(wr_command), .wr_address_i(wr_address), .wr_bank_i(wr_bank),
      .sd_command_o(sd_command), .sd_address_o(sd_address), .sd_bank_o(sd_bank),
      .refresh_late_o(refresh_late), .refresh_count_o(refresh_count),
      .rd_grant_count_o(rd_grant_count), .wr_grant_count_o(wr_grant_count));

   always #5 clk = ~clk;

   int cyc = 0;
   // edge counter used for absolute timing expectations
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model state: what the outputs must be after the latest edge
   int tmr = RI, sel = 0, last = 2, hold;
   bit pend_m = 0, late_m = 0, e_now = 0, pn = 0, en_rd = 0, en_wr = 0, ar_m = 0;
   logic [2:0]  cmd_m = NOP;
   logic [11:0] addr_m = '0;
   logic [15:0] rc = '0, rg = '0, wg = '0;

   task automatic step();
      @(posedge clk);
      e_now = init_done && tmr == 0;
      pn = pend_m || e_now;
      if (e_now) begin
         late_m = late_m | pend_m;
         pend_m = 1'b1;
         tmr = RI;
      end else if (init_done) tmr--;
   endtask

   task automatic refresh_seq();
      ar_m = 1'b1;
      cmd_m = PRE;
      addr_m = 12'h400;
      repeat (T_RP) begin
         step();
         cmd_m = NOP;
         addr_m = '0;
      end
      step();
      cmd_m = AR;
      repeat (T_RFC) begin
         step();
         cmd_m = NOP;
      end
      step();
      step();
      ar_m = 1'b0;
      pend_m = e_now;
      rc++;
   endtask

   task automatic serve(input int p);
      sel = p;
      last = p;
      if (p == 1) begin en_rd = 1'b1; rg++; end
      else begin en_wr = 1'b1; wg++; end
      hold = 0;
      forever begin
         step();
         hold++;
         if (pn || !(p == 1 ? rd_request : wr_request) || (hold >= MH && (p == 1 ? wr_request : rd_request))) break;
      end
      en_rd = 1'b0;
      en_wr = 1'b0;
      if (pn) ar_m = 1'b1;
      forever begin
         step();
         if (pn) ar_m = 1'b1;
         if (p == 1 ? rd_idle : wr_idle) break;
      end
      sel = 0;
      if (pn) refresh_seq();
   endtask

   // model: each pass of the loop is one IDLE decision
   initial begin
      wait (rst_n === 1'b1);
      forever begin
         step();
         if (init_done) begin
            if (pn) refresh_seq();
            else if (rd_request || wr_request)
               serve((rd_request && wr_request) ? 3 - last : (rd_request ? 1 : 2));
         end
      end
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) if (chk_on) begin
      chk("rd_enable", rd_enable, en_rd);
      chk("wr_enable", wr_enable, en_wr);
      chk("auto_refresh", auto_refresh, ar_m);
      chk("sd_command", sd_command, sel == 1 ? rd_command : sel == 2 ? wr_command : cmd_m);
      chk("sd_address", sd_address, sel == 1 ? rd_address : sel == 2 ? wr_address : addr_m);
      chk("sd_bank", sd_bank, sel == 1 ? rd_bank : sel == 2 ? wr_bank : 2'd0);
      chk("refresh_late", refresh_late, late_m);
      chk("refresh_count", refresh_count, STATS ? rc : 16'd0);
      chk("rd_grant_count", rd_grant_count, STATS ? rg : 16'd0);
      chk("wr_grant_count", wr_grant_count, STATS ? wg : 16'd0);
   end

   initial begin
      int n, e0, r0, len, who;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cmd", sd_command, NOP);
      chk("reset_addr", sd_address, 12'h000);
      chk("reset_enables", {rd_enable, wr_enable}, 2'b00);
      chk("reset_ar", auto_refresh, 0);
      chk("reset_late", refresh_late, 0);
      rd_request = 1'b1;
      wr_request = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;
      repeat (2000) @(posedge clk);
      #1;
      chk("noinit_enables", {rd_enable, wr_enable}, 2'b00);
      chk("noinit_cmd", sd_command, NOP);
      chk("noinit_ar", auto_refresh, 0);
      wr_request = 1'b0;
      init_done = 1'b1;
      e0 = cyc;
      @(negedge clk);
      chk("idle_cycle_rd_enable", rd_enable, 0);
      @(negedge clk);
      chk("first_grant_rd_enable", rd_enable, 1);
      chk("first_grant_cmd", sd_command, RDC);
      chk("first_grant_addr", sd_address, 12'h123);
      repeat (5) @(posedge clk);
      #1 rd_request = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd_request = 1'b1;
      wr_request = 1'b1;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!(rd_enable || wr_enable) && n < 50);
         who = rd_enable ? 1 : 2;
         chk("alternate_grant", who, (g % 2 == 0) ? 2 : 1);
         len = 0;
         while ((rd_enable || wr_enable) && len < 100) begin len++; @(negedge clk); end
         chk("hold_length", len, MH);
      end
      while (!auto_refresh && cyc < e0 + 900) @(negedge clk);
      chk("first_refresh_cycle", cyc, e0 + 781);
      chk("refresh_enables", {rd_enable, wr_enable}, 2'b00);
      chk("late_before", refresh_late, 0);
      n = 0;
      while (sd_command !== PRE && n < 40) begin @(negedge clk); n++; end
      chk("pre_cmd", sd_command, PRE);
      chk("pre_addr", sd_address, 12'h400);
      repeat (T_RP) begin @(negedge clk); chk("trp_nop", sd_command, NOP); end
      @(negedge clk);
      chk("ar_cmd", sd_command, AR);
      repeat (T_RFC) begin @(negedge clk); chk("trfc_nop", sd_command, NOP); end
      @(negedge clk);
      chk("wait_ar_high", auto_refresh, 1);
      @(negedge clk);
      chk("ar_cleared", auto_refresh, 0);
      chk("refresh_count_one", refresh_count, STATS ? 16'd1 : 16'd0);
      @(posedge clk);
      #1;
      wr_request = 1'b0;
      rd_idle = 1'b0;
      n = 0;
      while (!rd_enable && n < 60) begin @(negedge clk); n++; end
      chk("late_setup_rd_grant", rd_enable, 1);
      @(posedge clk);
      #1 rd_request = 1'b0;
      repeat (2 * RI + 20) @(posedge clk);
      #1;
      chk("late_set", refresh_late, 1);
      chk("late_ar_held", auto_refresh, 1);
      rd_idle = 1'b1;
      n = 0;
      while (sd_command !== AR && n < 30) begin @(negedge clk); n++; end
      chk("late_seq_ar", sd_command, AR);
      chk("late_sticky", refresh_late, 1);
      @(posedge clk);
      #1;
      chk_on = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_cmd", sd_command, NOP);
      chk("midrst_addr", sd_address, 12'h000);
      chk("midrst_enables", {rd_enable, wr_enable}, 2'b00);
      chk("midrst_ar", auto_refresh, 0);
      chk("midrst_late", refresh_late, 0);
      chk("midrst_count", refresh_count, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      r0 = cyc;
      while (!auto_refresh && cyc < r0 + 900) @(negedge clk);
      chk("post_reset_refresh_cycle", cyc, r0 + 781);
      chk("post_reset_late", refresh_late, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
